ir_nec_transmit: RTL and testbench

NEC infrared frame generator that produces the demodulated IR waveform consumed by the on-board IR receive stage. It accepts an address/command pair through a start/busy handshake and drives a serial level (`oIRDA`: idle high, burst low) with leader, 32 data bits and stop burst. Used for loopback test of the receive path and as the transmit half of the IR front end. An optional modulated 38 kHz LED drive is available.

---
 rtl/ir_nec_pkg.sv | 28 ++
 rtl/ir_nec_transmit_carrier.sv | 40 ++++
 rtl/ir_nec_transmit.sv | 141 ++++++++++++++
 tb/tb_ir_nec_transmit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: FSM state encoding, default segment timings
// (also used for the receive-side thresholds) and frame assembly.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LO,
    ST_LEAD_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_STOP_LO,
    ST_GAP
  } ir_state_e;

  localparam int NEC_LEADER_LO   = 450000;
  localparam int NEC_LEADER_HI   = 225000;
  localparam int NEC_BURST       = 28000;
  localparam int NEC_SPACE0      = 28000;
  localparam int NEC_SPACE1      = 84500;
  localparam int NEC_GAP         = 2000000;
  localparam int NEC_CARRIER_DIV = 1316;
  localparam int NEC_CNT_W       = 21;

  function automatic logic [31:0] nec_frame(input logic [15:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, addr};
  endfunction

endpackage

// File: rtl/ir_nec_transmit_carrier.sv
// 1/3-duty carrier for the IR LED; the phase restarts whenever a burst begins.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int DIV = NEC_CARRIER_DIV
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic en,
  output logic led
);

  localparam logic [15:0] HiLen = 16'(DIV / 3);
  localparam logic [15:0] Last  = 16'(DIV - 1);

  logic [15:0] phase_q, phase_d;
  logic        led_q, led_d;

  always_comb begin
    phase_d = 16'd0;
    led_d   = 1'b0;
    if (en) begin
      led_d   = (phase_q < HiLen);
      phase_d = (phase_q == Last) ? 16'd0 : phase_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      phase_q <= 16'd0;
      led_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC IR frame generator (leader, 32 bits LSB first, stop, gap).
// Optional 38 kHz LED modulation is built when IR_TX_CARRIER_EN is defined.
//
// state    | meaning
// IDLE     | waiting for iSTART
// LEAD_LO  | leader burst
// LEAD_HI  | leader space
// BIT_LO   | data bit burst
// BIT_HI   | data bit space (length depends on bit value)
// STOP_LO  | stop burst
// GAP      | mandatory high time before the next frame
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
  parameter int LEADER_LO = NEC_LEADER_LO,
  parameter int LEADER_HI = NEC_LEADER_HI,
  parameter int BURST     = NEC_BURST,
  parameter int SPACE0    = NEC_SPACE0,
  parameter int SPACE1    = NEC_SPACE1,
  parameter int GAP       = NEC_GAP
`ifdef IR_TX_CARRIER_EN
  , parameter int CARRIER_DIV = NEC_CARRIER_DIV
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic [15:0] iADDR,
  input  logic [7:0]  iCMD,
  output logic        oIRDA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oIR_LED
);

  ir_state_e              state_q, state_d;
  logic [NEC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [NEC_CNT_W-1:0]   seg_len;
  logic [4:0]             bit_q, bit_d;
  logic [31:0]            frame_q, frame_d;
  logic                   irda_q, irda_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   seg_end;
  logic                   burst;

  always_comb begin
    seg_len = 21'd1;
    unique case (state_q)
      ST_LEAD_LO: seg_len = 21'(LEADER_LO);
      ST_LEAD_HI: seg_len = 21'(LEADER_HI);
      ST_BIT_LO:  seg_len = 21'(BURST);
      ST_BIT_HI:  seg_len = frame_q[bit_q] ? 21'(SPACE1) : 21'(SPACE0);
      ST_STOP_LO: seg_len = 21'(BURST);
      ST_GAP:     seg_len = 21'(GAP);
      default:    seg_len = 21'd1;
    endcase
  end

  assign seg_end = (cnt_q == seg_len - 21'd1);
  assign burst   = (state_q == ST_LEAD_LO) || (state_q == ST_BIT_LO) || (state_q == ST_STOP_LO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 21'd1;
    bit_d   = bit_q;
    frame_d = frame_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      bit_d = '0;
      if (iSTART) begin
        state_d = ST_LEAD_LO;
        frame_d = nec_frame(iADDR, iCMD);
      end
    end else if (seg_end) begin
      cnt_d = '0;
      unique case (state_q)
        ST_LEAD_LO: state_d = ST_LEAD_HI;
        ST_LEAD_HI: state_d = ST_BIT_LO;
        ST_BIT_LO:  state_d = ST_BIT_HI;
        ST_BIT_HI: begin
          // bit index saturates at 31 so it never wraps inside a frame
          if (bit_q == 5'd31) begin
            state_d = ST_STOP_LO;
          end else begin
            state_d = ST_BIT_LO;
            bit_d   = bit_q + 5'd1;
          end
        end
        ST_STOP_LO: state_d = ST_GAP;
        ST_GAP:     state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the current state, so they trail it by one clock.
  always_comb begin
    irda_d = ~burst;
    done_d = (state_q == ST_GAP) && seg_end;
    busy_d = (state_q != ST_IDLE) && !done_d;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      irda_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      irda_q  <= irda_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oIRDA = irda_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;

`ifdef IR_TX_CARRIER_EN
  ir_carrier_gen #(
    .DIV(CARRIER_DIV)
  ) u_carrier (
    .clk_sys(iCLK),
    .rst_b  (iRST_n),
    .en     (burst),
    .led    (oIR_LED)
  );
`else
  assign oIR_LED = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Directed bench for ir_nec_transmit with shortened segment timings.
module tb_ir_nec_transmit;

  localparam int LL = 16;
  localparam int LH = 8;
  localparam int BU = 3;
  localparam int S0 = 3;
  localparam int S1 = 7;
  localparam int GP = 20;
`ifdef IR_TX_CARRIER_EN
  localparam int CD = 6;
`endif

  typedef struct {
    logic lvl;
    int   len;
    bit   exact;
  } run_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  cmd = '0;
  logic        irda, busy, done, led;

  always #5 clk = ~clk;

  ir_nec_transmit #(
    .LEADER_LO(LL), .LEADER_HI(LH), .BURST(BU), .SPACE0(S0), .SPACE1(S1), .GAP(GP)
`ifdef IR_TX_CARRIER_EN
    , .CARRIER_DIV(CD)
`endif
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .iSTART (start),
    .iADDR  (addr),
    .iCMD   (cmd),
    .oIRDA  (irda),
    .oBUSY  (busy),
    .oDONE  (done),
    .oIR_LED(led)
  );

  int errors = 0;
  int checks = 0;
  run_t        exp_q[$];
  logic [31:0] frame_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] f, input int idle_min, input bit idle_exact);
    exp_q.push_back('{1'b1, idle_min, idle_exact});
    exp_q.push_back('{1'b0, LL, 1'b1});
    exp_q.push_back('{1'b1, LH, 1'b1});
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{1'b0, BU, 1'b1});
      exp_q.push_back('{1'b1, f[i] ? S1 : S0, 1'b1});
    end
    exp_q.push_back('{1'b0, BU, 1'b1});
    frame_q.push_back(f);
  endtask

  // Line monitor and simple NEC receiver model
  logic        lvl = 1'b1;
  int          len = 0;
  int          rx_phase = 0;
  int          nbits = 0;
  logic [31:0] rx_word = '0;
  int          rx_cnt = 0;
  int          done_cnt = 0;

  task automatic end_run(input logic l, input int n);
    run_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL run_unexpected: observed level=%0d len=%0d expected none", l, n);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("run_level", l, e.lvl);
      if (e.exact) begin
        chk("run_len", n, e.len);
      end else begin
        checks++;
        assert (n >= e.len) else begin
          errors++;
          $error("FAIL run_min_len: observed=%0d required>=%0d", n, e.len);
        end
      end
    end
    if (l == 1'b0) begin
      if (n == LL) begin
        rx_phase = 1;
        nbits = 0;
      end else if (rx_phase == 2 && nbits == 32) begin
        rx_phase = 0;
        rx_cnt++;
        checks++;
        assert (frame_q.size() != 0) else begin
          errors++;
          $error("FAIL rx_unexpected_frame: observed=%0h expected none", rx_word);
        end
        if (frame_q.size() != 0) chk("rx_frame", rx_word, frame_q.pop_front());
      end
    end else begin
      if (rx_phase == 1) begin
        rx_phase = 2;
      end else if (rx_phase == 2 && nbits < 32) begin
        rx_word = {(n > (S0 + S1) / 2), rx_word[31:1]};
        nbits++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      lvl = 1'b1;
      len = 0;
      rx_phase = 0;
      nbits = 0;
    end else begin
      if (irda !== lvl) begin
        end_run(lvl, len);
        lvl = irda;
        len = 0;
      end
`ifdef IR_TX_CARRIER_EN
      chk("led", led, (irda === 1'b0) && ((len % CD) < CD / 3));
`else
      chk("led", led, 1'b0);
`endif
      len++;
      if (done) done_cnt++;
    end
  end

  int exp_done = 0;
  int exp_rx = 0;

  task automatic start_frame(input logic [15:0] a, input logic [7:0] c,
                             input logic [31:0] f, input int idle_min);
    push_frame(f, idle_min, 1'b0);
    @(negedge clk);
    start = 1'b1;
    addr = a;
    cmd = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    addr = 16'($urandom);
    cmd = 8'($urandom);
    chk("lat_irda_edge_n", irda, 1'b1);
    chk("lat_busy_edge_n", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_irda_edge_n1", irda, 1'b0);
    chk("lat_busy_edge_n1", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL done_timeout: observed no oDONE expected pulse within %0d cycles", budget);
    end
    if (found) begin
      exp_done++;
      chk("done_busy_low", busy, 1'b0);
      @(negedge clk);
      chk("done_width", done, 1'b0);
      chk("done_cnt", done_cnt, exp_done);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_irda", irda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_led", led, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic loopback frame
    start_frame(16'h00FF, 8'h1E, 32'hE11E00FF, 1);
    wait_done(2000);
    exp_rx++;
    chk("rx_cnt_basic", rx_cnt, exp_rx);

    // segment widths with command 0x0C
    start_frame(16'hA5C3, 8'h0C, 32'hF30CA5C3, GP + 1);
    wait_done(2000);
    exp_rx++;
    chk("rx_cnt_widths", rx_cnt, exp_rx);

    // start pulse while busy is ignored
    start_frame(16'h1234, 8'h55, 32'hAA551234, GP + 1);
    repeat (100) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    start = 1'b1;
    cmd = 8'h1F;
    addr = 16'hBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    exp_rx++;
    repeat (2 * GP) @(negedge clk);
    chk("no_queued_frame", busy, 1'b0);
    chk("rx_cnt_ignore", rx_cnt, exp_rx);

    // start held high: two back-to-back frames separated by the gap
    push_frame(32'h3CC30F0F, GP + 1, 1'b0);
    push_frame(32'h3CC30F0F, GP + 1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    addr = 16'h0F0F;
    cmd = 8'hC3;
    wait_done(2000);
    @(negedge clk);
    chk("held_rebusy", busy, 1'b1);
    start = 1'b0;
    wait_done(2000);
    exp_rx += 2;
    chk("rx_cnt_held", rx_cnt, exp_rx);

    // reset during bit 10
    start_frame(16'h5A5A, 8'h81, 32'h7E815A5A, GP + 1);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (rx_phase == 2 && nbits == 10) begin
          reached = 1'b1;
          break;
        end
      end
      checks++;
      assert (reached) else begin
        errors++;
        $error("FAIL bit10_timeout: observed nbits=%0d expected 10", nbits);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_irda", irda, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    exp_q.delete();
    frame_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (GP) @(negedge clk);
    chk("midrst_no_done", done_cnt, exp_done);
    chk("midrst_no_rx", rx_cnt, exp_rx);
    chk("midrst_idle_busy", busy, 1'b0);
    start_frame(16'hC0DE, 8'h42, 32'hBD42C0DE, 1);
    wait_done(2000);
    exp_rx++;
    chk("rx_cnt_after_rst", rx_cnt, exp_rx);

    chk("runs_left", exp_q.size(), 0);
    chk("frames_left", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
